// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
// The master drives the request and operands; the slave returns status and results.
interface serial_subtractor_if #(
  parameter int SIZE = 8
);
  logic            start;
  logic [SIZE-1:0] x;
  logic [SIZE-1:0] y;
  logic            bin;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] diff;
  logic            bout;
  logic            ovf;

  modport master (
    output start, x, y, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, x, y, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = x - y - bin, LSB first, one bit per clock,
// using one full-subtractor cell, a borrow flip-flop and a bit counter.
module serial_subtractor #(
  parameter int SIZE = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = ($clog2(SIZE) > 1) ? $clog2(SIZE) : 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t          state_r;
  logic [SIZE-1:0] xs_r;
  logic [SIZE-1:0] ys_r;
  logic            b_r;
  logic [CW-1:0]   cnt_r;
  logic            busy_r;
  logic            done_r;
  logic [SIZE-1:0] diff_r;
  logic            bout_r;
  logic            ovf_r;

  logic d_s;
  logic b_next_s;
  logic last_s;

  // Full-subtractor cell on the current LSBs plus last-bit detection
  always_comb begin
    d_s      = xs_r[0] ^ ys_r[0] ^ b_r;
    b_next_s = (~xs_r[0] & ys_r[0]) | (~(xs_r[0] ^ ys_r[0]) & b_r);
    last_s   = (cnt_r == CW'(SIZE - 1));
  end

  // Control FSM and datapath; every output is registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      xs_r    <= {SIZE{1'b0}};
      ys_r    <= {SIZE{1'b0}};
      b_r     <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      diff_r  <= {SIZE{1'b0}};
      bout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            xs_r    <= bus.x;
            ys_r    <= bus.y;
            b_r     <= bus.bin;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= SHIFT;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          xs_r   <= xs_r >> 1;
          ys_r   <= ys_r >> 1;
          b_r    <= b_next_s;
          diff_r <= {d_s, diff_r[SIZE-1:1]};
          if (last_s) begin
            // Overflow: borrow into the MSB differs from borrow out of it
            bout_r  <= b_next_s;
            ovf_r   <= b_r ^ b_next_s;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            state_r <= IDLE;
          end else begin
            cnt_r   <= cnt_r + CW'(1);
            state_r <= SHIFT;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.diff = diff_r;
  assign bus.bout = bout_r;
  assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance with hand-computed
// vectors and a 4-bit instance swept exhaustively against an integer model.
module tb_serial_subtractor;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  serial_subtractor_if #(.SIZE(8)) bus8 ();
  serial_subtractor_if #(.SIZE(4)) bus4 ();

  serial_subtractor #(.SIZE(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_subtractor #(.SIZE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Accept a start on the next edge, then wait (bounded) for done.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                     output int lat, output int busy_cycles);
    bus8.x = a; bus8.y = b; bus8.bin = bi; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    lat = 0; busy_cycles = 0;
    while (!bus8.done && lat < 20) begin
      if (bus8.busy) busy_cycles++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bi, output int lat);
    bus4.x = a; bus4.y = b; bus4.bin = bi; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    lat = 0;
    while (!bus4.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bc;
    int full;
    int sres;
    int sa;
    int sb;
    vectors = 0; miscompares = 0;
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.x = 8'h00; bus8.y = 8'h00; bus8.bin = 1'b0;
    bus4.start = 1'b0; bus4.x = 4'h0; bus4.y = 4'h0; bus4.bin = 1'b0;
    #3;
    chk("reset_busy", {31'd0, bus8.busy}, 32'd0);
    chk("reset_done", {31'd0, bus8.done}, 32'd0);
    chk("reset_diff", {24'd0, bus8.diff}, 32'd0);
    chk("reset_bout_ovf", {30'd0, bus8.bout, bus8.ovf}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 100 - 37 = 63
    op8(8'd100, 8'd37, 1'b0, lat, bc);
    chk("basic_latency", lat, 32'd8);
    chk("basic_busy_cycles", bc, 32'd8);
    chk("basic_diff", {24'd0, bus8.diff}, 32'h3F);
    chk("basic_bout_ovf", {30'd0, bus8.bout, bus8.ovf}, 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, bus8.done}, 32'd0);

    op8(8'd5, 8'd9, 1'b0, lat, bc);
    chk("neg_diff", {24'd0, bus8.diff}, 32'hFC);
    chk("neg_bout_ovf", {30'd0, bus8.bout, bus8.ovf}, 32'b10);
    op8(8'h00, 8'h00, 1'b1, lat, bc);
    chk("bin_diff", {24'd0, bus8.diff}, 32'hFF);
    chk("bin_bout_ovf", {30'd0, bus8.bout, bus8.ovf}, 32'b10);
    op8(8'h80, 8'h01, 1'b0, lat, bc);
    chk("ovf1_diff", {24'd0, bus8.diff}, 32'h7F);
    chk("ovf1_bout_ovf", {30'd0, bus8.bout, bus8.ovf}, 32'b01);
    op8(8'h7F, 8'hFF, 1'b0, lat, bc);
    chk("ovf2_diff", {24'd0, bus8.diff}, 32'h80);
    chk("ovf2_bout_ovf", {30'd0, bus8.bout, bus8.ovf}, 32'b11);
    @(posedge clk); #1;

    // Re-pulse start and change operands while busy
    bus8.x = 8'd100; bus8.y = 8'd37; bus8.bin = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    lat = 0;
    while (!bus8.done && lat < 20) begin
      if (lat == 2) begin
        bus8.start = 1'b1; bus8.x = 8'hEE; bus8.y = 8'h11; bus8.bin = 1'b1;
      end else begin
        bus8.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("repulse_latency", lat, 32'd8);
    chk("repulse_diff", {24'd0, bus8.diff}, 32'h3F);
    chk("repulse_bout_ovf", {30'd0, bus8.bout, bus8.ovf}, 32'd0);

    // Back-to-back: start during the done cycle
    bus8.x = 8'h10; bus8.y = 8'h01; bus8.bin = 1'b0; bus8.start = 1'b1;
    #2;
    chk("b2b_first_visible", {24'd0, bus8.diff}, 32'h3F);
    @(posedge clk); #1;
    bus8.start = 1'b0;
    chk("b2b_done_drops", {31'd0, bus8.done}, 32'd0);
    chk("b2b_busy", {31'd0, bus8.busy}, 32'd1);
    lat = 0;
    while (!bus8.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_latency", lat, 32'd8);
    chk("b2b_diff", {24'd0, bus8.diff}, 32'h0F);
    @(posedge clk); #1;

    // Reset mid-operation
    bus8.x = 8'hAA; bus8.y = 8'h11; bus8.bin = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus8.busy}, 32'd0);
    chk("abort_done", {31'd0, bus8.done}, 32'd0);
    chk("abort_diff", {24'd0, bus8.diff}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bc = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus8.done) bc++;
    end
    chk("abort_no_done", bc, 32'd0);
    op8(8'd3, 8'd3, 1'b0, lat, bc);
    chk("post_reset_latency", lat, 32'd8);
    chk("post_reset_diff", {24'd0, bus8.diff}, 32'd0);
    chk("post_reset_bout", {31'd0, bus8.bout}, 32'd0);

    // Exhaustive 4-bit sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          op4(4'(a), 4'(b), 1'(c), lat);
          full = a - b - c;
          sa   = (a >= 8) ? a - 16 : a;
          sb   = (b >= 8) ? b - 16 : b;
          sres = sa - sb - c;
          chk("sweep_latency", lat, 32'd4);
          chk("sweep_diff", {28'd0, bus4.diff}, 32'(full & 15));
          chk("sweep_bout", {31'd0, bus4.bout}, (full < 0) ? 32'd1 : 32'd0);
          chk("sweep_ovf", {31'd0, bus4.ovf}, (sres < -8 || sres > 7) ? 32'd1 : 32'd0);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
